crypto_exec_unit: RTL and testbench
===================================

# crypto_exec_unit

Multi-cycle execution stage that sits directly downstream of the 8-bit general-purpose register file. It consumes operands A (data) and B (key), performs one of four byte-wide cipher primitives, and writes the result back into the register file's `out` register through its write port (`we_reg`/`reg_select`/`data_in`). A start/busy/done handshake lets the control sequencer launch one operation at a time.

## Interface
- `ROUNDS`, 4: ARX round count for op 2'b11; legal range 1..15.
- `WB_SEL`, 2'b10: register-file select used for write-back (the `out` register).

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  launch request; sampled only in IDLE.
- `op`  in  2  00 XOR, 01 ROTL, 10 ADD, 11 ARX.
- `A`  in  8  data operand from register file.
- `B`  in  8  key/shift operand from register file.
- `busy`  out  1  high from the cycle after `start` is accepted until write-back completes.
- `done`  out  1  one-cycle pulse, coincident with write-back.
- `result`  out  8  last computed result; held until the next write-back.
- `we_reg`  out  1  register-file write enable; one-cycle pulse.
- `reg_select`  out  2  register-file select; `WB_SEL` during write-back, else 2'b00.
- `data_in`  out  8  register-file write data; equals `result` during write-back, else 8'h00.

## Operation
- FSM states: IDLE, EXEC, WB.
- IDLE: on `start`=1, latch `A`→x, `B`→k, `op`→op_q, clear round counter, go to EXEC. `start`=0: stay.
- EXEC, op XOR/ROTL/ADD: single cycle; x ← A^B, rotl(A, B[2:0]), or (A+B) mod 256. Go to WB.
- EXEC, op ARX: one round per cycle; x ← rotl(x+k mod 256, 3) ^ k; k ← rotl(k, 1); counter++. Go to WB after round `ROUNDS`-1.
- WB: `we_reg`=1, `reg_select`=`WB_SEL`, `data_in`=x, `done`=1, `result` ← x. Return to IDLE.
- `start` in EXEC/WB is ignored, not queued. `start` in the IDLE cycle directly after WB is accepted normally.
- `A`/`B`/`op` changes after acceptance have no effect; operands are latched.
- Arithmetic is 8-bit, carry discarded. Rotations are circular left shifts. A rotate amount of 0 returns A unchanged.

## Timing
- Reset (any state): FSM→IDLE. `busy`, `done`, `we_reg` = 0. `reg_select`=2'b00. `data_in`, `result`, x, k, counter = 0. An in-flight operation is abandoned with no write-back.
- All outputs are registered or decoded only from state. No combinational path from input to output.
- `start` accepted at edge t0. `busy`=1 from t0.
- Non-ARX ops: EXEC occupies cycle t0..t1; WB (`we_reg`/`done`) occupies t1..t2; `busy` falls at t2.
- ARX: EXEC occupies `ROUNDS` cycles; WB at t0+`ROUNDS`.
- Busy duration is 2 cycles for non-ARX ops and `ROUNDS`+1 cycles for ARX.
- The register file captures `data_in` on the edge that ends the WB cycle. `result` updates on the same edge.

## Structure
- Shared package `crypto_pkg` holds:
  - op encodings (OP_XOR, OP_ROTL, OP_ADD, OP_ARX);
  - FSM state enum;
  - register-select constants (SEL_A=2'b00, SEL_B=2'b01, SEL_OUT=2'b10).
- One combinational sub-module, `arx_round`, takes (x, k) and returns (x', k'). It is reusable by later cipher stages.
- Round counter is 4 bits.

## Test plan
- Reset mid-ARX (`rst_n` low in the 2nd EXEC cycle) → `busy`=0 immediately. No `we_reg` pulse ever follows. `result`=8'h00.
- op XOR, A=8'hAA, B=8'hCC, `start` 1 cycle → `we_reg`/`done` high exactly one cycle, 2 cycles after acceptance, with `reg_select`=2'b10 and `data_in`=8'h66.
- op ADD, A=8'hF0, B=8'h20 → `data_in`=8'h10 (wrap). op ROTL, A=8'h81, B=8'h09 → 8'h03 (only B[2:0] used).
- op ARX, ROUNDS=4, A=8'h00, B=8'h01 → `busy` for 5 cycles, write-back 8'hFF. With ROUNDS=2 → 8'h5A.
- `start` held high through an ARX op with A changed mid-op → single write-back of the original-operand result. A second operation starts in the IDLE cycle after WB.
- Back-to-back: XOR then ADD, with `start` pulsed on each IDLE → two distinct write-backs. `result` holds its value between them.

Source files
------------

// File: rtl/crypto_exec_unit_pkg.sv
// Shared definitions for the byte-wide cipher execution stage.
package crypto_pkg;

  typedef enum logic [1:0] {
    OP_XOR  = 2'b00,
    OP_ROTL = 2'b01,
    OP_ADD  = 2'b10,
    OP_ARX  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_WB   = 2'b10
  } state_e;

  localparam logic [1:0] SEL_A   = 2'b00;
  localparam logic [1:0] SEL_B   = 2'b01;
  localparam logic [1:0] SEL_OUT = 2'b10;

  // Circular left rotate of a byte; the upper half of the doubled word holds the result.
  function automatic logic [7:0] rotl8(input logic [7:0] v, input logic [2:0] n);
    logic [15:0] w_dbl;
    w_dbl = {v, v} << n;
    return w_dbl[15:8];
  endfunction

endpackage

// File: rtl/crypto_exec_unit_arx_round.sv
// One combinational add-rotate-xor round with key schedule step.
module arx_round
  import crypto_pkg::*;
(
  input  logic [7:0] i_x,
  input  logic [7:0] i_k,
  output logic [7:0] o_x,
  output logic [7:0] o_k
);

  logic [7:0] w_sum;

  assign w_sum = i_x + i_k;
  assign o_x   = rotl8(w_sum, 3'd3) ^ i_k;
  assign o_k   = rotl8(i_k, 3'd1);

endmodule

// File: rtl/crypto_exec_unit.sv
// Multi-cycle cipher execution stage: latches operands, computes one primitive,
// then writes the byte back into the register file's out register.
module crypto_exec_unit
  import crypto_pkg::*;
#(
  parameter int unsigned ROUNDS = 4,
  parameter logic [1:0]  WB_SEL = SEL_OUT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [7:0] A,
  input  logic [7:0] B,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       we_reg,
  output logic [1:0] reg_select,
  output logic [7:0] data_in
);

  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

  state_e     r_state;
  state_e     w_state_nxt;
  op_e        r_op;
  op_e        w_op_nxt;
  logic [7:0] r_x;
  logic [7:0] w_x_nxt;
  logic [7:0] r_k;
  logic [7:0] w_k_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic [7:0] r_result;
  logic [7:0] w_result_nxt;
  logic [7:0] w_arx_x;
  logic [7:0] w_arx_k;

  arx_round u_arx_round (
    .i_x (r_x),
    .i_k (r_k),
    .o_x (w_arx_x),
    .o_k (w_arx_k)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath update selection.
  always_comb begin
    w_state_nxt  = r_state;
    w_op_nxt     = r_op;
    w_x_nxt      = r_x;
    w_k_nxt      = r_k;
    w_cnt_nxt    = r_cnt;
    w_result_nxt = r_result;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_op_nxt    = op_e'(op);
          w_x_nxt     = A;
          w_k_nxt     = B;
          w_cnt_nxt   = 4'd0;
          w_state_nxt = S_EXEC;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_EXEC: begin
        case (r_op)
          OP_XOR:  w_x_nxt = r_x ^ r_k;
          OP_ROTL: w_x_nxt = rotl8(r_x, r_k[2:0]);
          OP_ADD:  w_x_nxt = r_x + r_k;
          OP_ARX: begin
            w_x_nxt   = w_arx_x;
            w_k_nxt   = w_arx_k;
            w_cnt_nxt = r_cnt + 4'd1;
          end
          default: w_x_nxt = r_x;
        endcase
        if ((r_op != OP_ARX) || (r_cnt == LAST_ROUND)) begin
          w_state_nxt = S_WB;
        end else begin
          w_state_nxt = S_EXEC;
        end
      end
      S_WB: begin
        w_result_nxt = r_x;
        w_state_nxt  = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand, key, round counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= OP_XOR;
      r_x      <= 8'h00;
      r_k      <= 8'h00;
      r_cnt    <= 4'd0;
      r_result <= 8'h00;
    end else begin
      r_op     <= w_op_nxt;
      r_x      <= w_x_nxt;
      r_k      <= w_k_nxt;
      r_cnt    <= w_cnt_nxt;
      r_result <= w_result_nxt;
    end
  end

  // Outputs decode only from state and registers, so no input reaches an output.
  assign busy       = (r_state != S_IDLE);
  assign we_reg     = (r_state == S_WB);
  assign done       = (r_state == S_WB);
  assign reg_select = (r_state == S_WB) ? WB_SEL : SEL_A;
  assign data_in    = (r_state == S_WB) ? r_x : 8'h00;
  assign result     = r_result;

endmodule

// File: tb/tb_crypto_exec_unit.sv
// Directed bench for crypto_exec_unit with a write-back scoreboard; a second
// instance with two ARX rounds checks the round-count parameter.
module tb_crypto_exec_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       start2 = 1'b0;
  logic [1:0] op = 2'b00;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;

  logic       busy, done, we_reg;
  logic [1:0] reg_select;
  logic [7:0] result, data_in;
  logic       busy2, done2, we_reg2;
  logic [1:0] reg_select2;
  logic [7:0] result2, data_in2;

  int checks = 0;
  int errors = 0;
  int wb_cnt = 0;
  int busy_cycles;
  logic [7:0] q1[$];
  logic [7:0] q2[$];

  always #5 clk = ~clk;

  crypto_exec_unit #(.ROUNDS(4), .WB_SEL(2'b10)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(a), .B(b),
    .busy(busy), .done(done), .result(result), .we_reg(we_reg),
    .reg_select(reg_select), .data_in(data_in)
  );

  crypto_exec_unit #(.ROUNDS(2), .WB_SEL(2'b10)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .op(op), .A(a), .B(b),
    .busy(busy2), .done(done2), .result(result2), .we_reg(we_reg2),
    .reg_select(reg_select2), .data_in(data_in2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard for the 4-round instance.
  always @(negedge clk) begin
    if (we_reg === 1'b1) begin
      wb_cnt++;
      checks++;
      assert (q1.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_wb observed=%0h expected=none", data_in);
      end
      if (q1.size() > 0) begin
        chk("wb_data", {24'd0, data_in}, {24'd0, q1.pop_front()});
        chk("wb_sel", {30'd0, reg_select}, 32'd2);
        chk("wb_done", {31'd0, done}, 32'd1);
      end
    end
  end

  // Scoreboard for the 2-round instance.
  always @(negedge clk) begin
    if (we_reg2 === 1'b1) begin
      checks++;
      assert (q2.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_wb2 observed=%0h expected=none", data_in2);
      end
      if (q2.size() > 0) begin
        chk("wb2_data", {24'd0, data_in2}, {24'd0, q2.pop_front()});
      end
    end
  end

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_we", {31'd0, we_reg}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sel", {30'd0, reg_select}, 32'd0);
    chk("rst_data_in", {24'd0, data_in}, 32'd0);
    chk("rst_result", {24'd0, result}, 32'd0);
    rst_n = 1'b1;

    // ARX abandoned by reset in its second EXEC cycle.
    @(negedge clk);
    op = 2'b11; a = 8'h00; b = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_no_wb", wb_cnt, 32'd0);
    chk("abort_result", {24'd0, result}, 32'd0);

    // XOR with exact write-back timing.
    op = 2'b00; a = 8'hAA; b = 8'hCC; start = 1'b1; q1.push_back(8'h66);
    @(negedge clk);
    start = 1'b0;
    chk("xor_busy_exec", {31'd0, busy}, 32'd1);
    chk("xor_we_exec", {31'd0, we_reg}, 32'd0);
    @(negedge clk);
    chk("xor_we_wb", {31'd0, we_reg}, 32'd1);
    chk("xor_data_in", {24'd0, data_in}, 32'h66);
    @(negedge clk);
    chk("xor_we_after", {31'd0, we_reg}, 32'd0);
    chk("xor_busy_after", {31'd0, busy}, 32'd0);
    chk("xor_data_in_idle", {24'd0, data_in}, 32'd0);
    chk("xor_result", {24'd0, result}, 32'h66);

    // Back-to-back ADD with wrap; result holds the XOR value until its write-back ends.
    op = 2'b10; a = 8'hF0; b = 8'h20; start = 1'b1; q1.push_back(8'h10);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("add_result_held", {24'd0, result}, 32'h66);
    @(negedge clk);
    chk("add_result", {24'd0, result}, 32'h10);

    // ROTL uses only B[2:0]; a zero amount leaves A unchanged.
    op = 2'b01; a = 8'h81; b = 8'h09; start = 1'b1; q1.push_back(8'h03);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rotl_result", {24'd0, result}, 32'h03);
    op = 2'b01; a = 8'h3C; b = 8'h08; start = 1'b1; q1.push_back(8'h3C);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rotl0_result", {24'd0, result}, 32'h3C);

    // ARX with start held high and operands changed mid-operation.
    op = 2'b11; a = 8'h00; b = 8'h01; start = 1'b1; q1.push_back(8'hFF);
    @(negedge clk);
    a = 8'h55; b = 8'h77; op = 2'b00;
    busy_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy !== 1'b1) break;
      busy_cycles++;
      @(negedge clk);
    end
    chk("arx_busy_cycles", busy_cycles, 32'd5);
    chk("arx_result", {24'd0, result}, 32'hFF);
    q1.push_back(8'h22);
    @(negedge clk);
    start = 1'b0;
    chk("second_op_busy", {31'd0, busy}, 32'd1);
    repeat (2) @(negedge clk);
    chk("second_op_result", {24'd0, result}, 32'h22);

    // Two-round ARX instance.
    op = 2'b11; a = 8'h00; b = 8'h01; start2 = 1'b1; q2.push_back(8'h5A);
    @(negedge clk);
    start2 = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy2 !== 1'b1) break;
      busy_cycles++;
      @(negedge clk);
    end
    chk("arx2_busy_cycles", busy_cycles, 32'd3);
    chk("arx2_result", {24'd0, result2}, 32'h5A);

    repeat (3) @(negedge clk);
    chk("q1_drained", q1.size(), 32'd0);
    chk("q2_drained", q2.size(), 32'd0);
    chk("wb_total", wb_cnt, 32'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
